// File: rtl/camera_cfg_pkg.sv
// Shared definitions for the camera configuration path.
// Contents:
//   sccb_state_e    - SCCB write engine states
//   OV5640_I2C_ADDR - 8-bit write address of the OV5640 sensor
//   BitsPerByte     - bit slots per byte, including the ACK slot
//   ClkDivDefault   - default clk_25M cycles per quarter SCL period (~100.8 kHz SCL)
package camera_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBits,
        StStop,
        StDone
    } sccb_state_e;

    localparam logic [7:0]  OV5640_I2C_ADDR = 8'h78;
    localparam int unsigned BitsPerByte     = 9;
    localparam int unsigned ClkDivDefault   = 62;

endpackage

// File: rtl/sccb_quarter_tick.sv
// Quarter-bit tick generator for the SCCB write engine.
// Counts ClkDiv cycles and emits a registered one-cycle tick at the end of each count.
// Ports:
//   clk_i  - system clock
//   en_i   - count enable
//   clr_i  - synchronous clear of counter and tick (wins over en_i)
//   tick_o - one-cycle pulse every ClkDiv enabled cycles
module sccb_quarter_tick #(
    parameter int unsigned ClkDiv = 62
) (
    input  logic clk_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(ClkDiv);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == CntW'(ClkDiv - 1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/sccb_write_master.sv
// SCCB/I2C write master: turns one request {dev addr, reg hi, reg lo, data} into a
// START, NUM_BYTES x (8 data bits + ACK slot), STOP frame. Each bit slot is four
// quarters of CLK_DIV clk_25M cycles. Bus outputs are registered.
// Ports:
//   clk_25M    - 25 MHz system clock
//   camera_rst - synchronous active-high reset
//   start      - level request; launches a frame from IDLE
//   i2c_data   - frame contents, MSB first, captured at launch
//   tr_end     - frame complete, held until start drops
//   ack        - 1 = some ACK slot of the last frame read high (NACK)
//   busy       - frame in progress
//   i2c_sclk   - SCL, push-pull
//   i2c_sdat   - SDA, open-drain (drives 0 or releases)
module sccb_write_master
    import camera_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV   = ClkDivDefault,
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                   clk_25M,
    input  logic                   camera_rst,
    input  logic                   start,
    input  logic [NUM_BYTES*8-1:0] i2c_data,
    output logic                   tr_end,
    output logic                   ack,
    output logic                   busy,
    output logic                   i2c_sclk,
    inout  wire                    i2c_sdat
);

    localparam int unsigned DataW   = NUM_BYTES * 8;
    localparam int unsigned ByteW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [3:0]  AckSlot = 4'(BitsPerByte - 1);

    sccb_state_e      state_q, state_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_q, bit_d;
    logic [ByteW-1:0] byte_q, byte_d;
    logic [DataW-1:0] shift_q, shift_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             tr_end_q, tr_end_d;
    logic             scl_q, scl_d;
    logic             sda_low_q, sda_low_d;

    logic tick;
    logic sda_in;
    logic ack_slot;
    logic last_byte;

    // Counter idles at zero so the first quarter is aligned to the launch edge.
    sccb_quarter_tick #(
        .ClkDiv (CLK_DIV)
    ) u_tick (
        .clk_i  (clk_25M),
        .en_i   (busy_q),
        .clr_i  (camera_rst | ~busy_q),
        .tick_o (tick)
    );

    assign sda_in    = i2c_sdat;
    assign ack_slot  = (bit_q == AckSlot);
    assign last_byte = (byte_q == ByteW'(NUM_BYTES - 1));

    always_comb begin
        state_d  = state_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        tr_end_d = tr_end_q;

        case (state_q)
            StIdle: begin
                if (start && !tr_end_q) begin
                    shift_d = i2c_data;
                    ack_d   = 1'b0;
                    busy_d  = 1'b1;
                    qtr_d   = 2'd0;
                    bit_d   = 4'd0;
                    byte_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        bit_d   = 4'd0;
                        byte_d  = '0;
                        state_d = StBits;
                    end
                end
            end
            StBits: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    // ACK sampled at the end of the second SCL-high quarter; sticky per frame.
                    if (qtr_q == 2'd2 && ack_slot && sda_in) begin
                        ack_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        if (ack_slot) begin
                            bit_d = 4'd0;
                            if (last_byte) begin
                                state_d = StStop;
                            end else begin
                                byte_d = byte_q + 1'b1;
                            end
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shift_d = {shift_q[DataW-2:0], 1'b0};
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        busy_d   = 1'b0;
                        tr_end_d = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (!start) begin
                    tr_end_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus levels are decoded from the next position so they register with it.
    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state_d)
            StStart: begin
                scl_d     = (qtr_d != 2'd3);
                sda_low_d = qtr_d[1];
            end
            StBits: begin
                scl_d     = qtr_d[0] ^ qtr_d[1];
                sda_low_d = (bit_d != AckSlot) && !shift_d[DataW-1];
            end
            StStop: begin
                scl_d     = (qtr_d != 2'd0);
                sda_low_d = !qtr_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_25M) begin
        if (camera_rst) begin
            state_q   <= StIdle;
            qtr_q     <= 2'd0;
            bit_q     <= 4'd0;
            byte_q    <= '0;
            shift_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            tr_end_q  <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            tr_end_q  <= tr_end_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign tr_end   = tr_end_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign i2c_sclk = scl_q;
    assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master with CLK_DIV=4 and an I2C slave/bus monitor model.
module tb_sccb_write_master;
    import camera_cfg_pkg::*;

    localparam int unsigned ClkDiv   = 4;
    localparam int          FrameLat = 152 * ClkDiv + 1;

    logic        clk;
    logic        camera_rst;
    logic        start;
    logic [31:0] i2c_data;
    logic        tr_end;
    logic        ack;
    logic        busy;
    logic        scl;
    wire         sda_bus;

    logic        slave_drive;
    logic [3:0]  nack_mask;

    assign sda_bus = slave_drive ? 1'b0 : 1'bz;
    pullup (sda_bus);

    sccb_write_master #(
        .CLK_DIV   (ClkDiv),
        .NUM_BYTES (4)
    ) dut (
        .clk_25M    (clk),
        .camera_rst (camera_rst),
        .start      (start),
        .i2c_data   (i2c_data),
        .tr_end     (tr_end),
        .ack        (ack),
        .busy       (busy),
        .i2c_sclk   (scl),
        .i2c_sdat   (sda_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Bus monitor + slave, sampled on the falling clock edge.
    int          start_cnt, stop_cnt, rise_cnt, slot_cnt, order_err;
    int          slot_idx, byte_idx;
    logic        prev_scl, prev_sda, sda_v, last_start;
    logic [31:0] cap_bytes;
    logic [3:0]  cap_acks;
    logic [31:0] rec_q[$];

    initial begin
        start_cnt = 0; stop_cnt = 0; rise_cnt = 0; slot_cnt = 0; order_err = 0;
        slot_idx = 0; byte_idx = 4; prev_scl = 1'b1; prev_sda = 1'b1; last_start = 1'b0;
        cap_bytes = '0; cap_acks = 4'hf; slave_drive = 1'b0; nack_mask = 4'h0;
        forever begin
            @(negedge clk);
            sda_v = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
            if (prev_scl && scl === 1'b1 && prev_sda && !sda_v) begin
                start_cnt++;
                if (last_start) order_err++;
                last_start  = 1'b1;
                slot_idx    = 0;
                byte_idx    = 0;
                cap_bytes   = '0;
                cap_acks    = 4'hf;
                slave_drive = 1'b0;
            end else if (prev_scl && scl === 1'b1 && !prev_sda && sda_v) begin
                stop_cnt++;
                if (!last_start) order_err++;
                last_start  = 1'b0;
                if (byte_idx == 4 && slot_idx == 0) rec_q.push_back(cap_bytes);
                slave_drive = 1'b0;
            end
            if (!prev_scl && scl === 1'b1) begin
                rise_cnt++;
                if (byte_idx < 4) begin
                    slot_cnt++;
                    if (slot_idx < 8) cap_bytes = {cap_bytes[30:0], sda_v};
                    else cap_acks[byte_idx] = sda_v;
                    if (slot_idx == 8) begin
                        slot_idx = 0;
                        byte_idx++;
                    end else begin
                        slot_idx++;
                    end
                end
            end
            if (prev_scl && scl === 1'b0) begin
                slave_drive = 1'b0;
                if (slot_idx == 8 && byte_idx < 4) slave_drive = !nack_mask[byte_idx];
            end
            prev_scl = (scl === 1'b1);
            prev_sda = sda_v;
        end
    end

    // Launch one frame (caller sits just after a rising edge) and wait for tr_end.
    // cycles counts edges after the launch edge; -1 if the budget expires.
    task automatic run_frame(input logic [31:0] d, input logic [3:0] nm, input int drop_at,
                             output int cycles);
        nack_mask = nm;
        i2c_data  = d;
        start     = 1'b1;
        @(posedge clk); #1;
        i2c_data = ~d;
        cycles   = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (n == drop_at) start = 1'b0;
            if (tr_end === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic drop_start();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        camera_rst = 1'b1;
        start      = 1'b0;
        i2c_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        camera_rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl got %b want 1", scl); end
        n_cmp++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_sda got %b want 1", sda_bus); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (tr_end !== 1'b0) begin n_fail++; $display("FAIL reset_tr_end got %b want 0", tr_end); end
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
    endtask

    task automatic test_basic_frame();
        int          cyc, s0, p0, sl0;
        logic [31:0] d;
        d  = {OV5640_I2C_ADDR, 24'h31_03_11};
        s0 = start_cnt; p0 = stop_cnt; sl0 = slot_cnt;
        run_frame(d, 4'h0, 0, cyc);
        n_cmp++; if (cyc != FrameLat) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", cyc, FrameLat); end
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack got %b want 0", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", busy); end
        n_cmp++; if (cap_bytes !== 32'h78310311) begin n_fail++; $display("FAIL basic_bytes got %h want 78310311", cap_bytes); end
        n_cmp++; if (cap_acks !== 4'h0) begin n_fail++; $display("FAIL basic_ack_slots got %b want 0000", cap_acks); end
        n_cmp++; if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL basic_start_cond got %0d want 1", start_cnt - s0); end
        n_cmp++; if (stop_cnt - p0 != 1) begin n_fail++; $display("FAIL basic_stop_cond got %0d want 1", stop_cnt - p0); end
        n_cmp++; if (slot_cnt - sl0 != 36) begin n_fail++; $display("FAIL basic_slots got %0d want 36", slot_cnt - sl0); end
        drop_start();
    endtask

    task automatic test_nack();
        int cyc, p0, sl0;
        p0 = stop_cnt; sl0 = slot_cnt;
        run_frame(32'h78_50_1D_40, 4'b0100, 0, cyc);
        n_cmp++; if (cyc != FrameLat) begin n_fail++; $display("FAIL nack_latency got %0d want %0d", cyc, FrameLat); end
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL nack_ack got %b want 1", ack); end
        n_cmp++; if (cap_acks !== 4'b0100) begin n_fail++; $display("FAIL nack_ack_slots got %b want 0100", cap_acks); end
        n_cmp++; if (slot_cnt - sl0 != 36) begin n_fail++; $display("FAIL nack_slots got %0d want 36", slot_cnt - sl0); end
        n_cmp++; if (stop_cnt - p0 != 1) begin n_fail++; $display("FAIL nack_stop got %0d want 1", stop_cnt - p0); end
        n_cmp++; if (cap_bytes !== 32'h78501D40) begin n_fail++; $display("FAIL nack_bytes got %h want 78501d40", cap_bytes); end
        drop_start();
        // Next frame: ack clears at launch and stays clear with full ACKs.
        nack_mask = 4'h0;
        i2c_data  = 32'h78_30_08_02;
        start     = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL nack_clear_at_launch got %b want 0", ack); end
        start = 1'b0;
        cyc   = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (tr_end === 1'b1) begin cyc = n; break; end
        end
        n_cmp++; if (cyc != FrameLat) begin n_fail++; $display("FAIL recover_latency got %0d want %0d", cyc, FrameLat); end
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL recover_ack got %b want 0", ack); end
        @(posedge clk); #1;
    endtask

    task automatic test_hold_start();
        int cyc, r0, hold_bad;
        run_frame(32'h78_30_08_82, 4'h0, 0, cyc);
        r0       = rise_cnt;
        hold_bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (tr_end !== 1'b1) hold_bad++;
        end
        n_cmp++; if (hold_bad != 0) begin n_fail++; $display("FAIL hold_tr_end low_cycles got %0d want 0", hold_bad); end
        n_cmp++; if (rise_cnt - r0 != 0) begin n_fail++; $display("FAIL hold_scl_edges got %0d want 0", rise_cnt - r0); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy got %b want 0", busy); end
        drop_start();
        n_cmp++; if (tr_end !== 1'b0) begin n_fail++; $display("FAIL hold_release got %b want 0", tr_end); end
        run_frame(32'h78_47_40_00, 4'h0, 0, cyc);
        n_cmp++; if (cyc != FrameLat) begin n_fail++; $display("FAIL hold_relaunch got %0d want %0d", cyc, FrameLat); end
        n_cmp++; if (cap_bytes !== 32'h78474000) begin n_fail++; $display("FAIL hold_relaunch_bytes got %h want 78474000", cap_bytes); end
        drop_start();
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        nack_mask = 4'h0;
        i2c_data  = 32'h78310311;
        start     = 1'b1;
        @(posedge clk); #1;
        // Byte 2 bit 5 is slot 23; its quarter 2 (quarter 98) spans edges 393..397.
        repeat (394) @(posedge clk);
        #1;
        n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL mid_scl_before got %b want 1", scl); end
        n_cmp++; if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL mid_sda_before got %b want 0", sda_bus); end
        camera_rst = 1'b1;
        start      = 1'b0;
        @(posedge clk); #1;
        camera_rst = 1'b0;
        n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL mid_rst_scl got %b want 1", scl); end
        n_cmp++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL mid_rst_sda got %b want 1", sda_bus); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_cmp++; if (tr_end !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tr_end got %b want 0", tr_end); end
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack got %b want 0", ack); end
        @(posedge clk); #1;
        run_frame(32'h78_36_12_a5, 4'h0, 0, cyc);
        n_cmp++; if (cyc != FrameLat) begin n_fail++; $display("FAIL mid_next_latency got %0d want %0d", cyc, FrameLat); end
        n_cmp++; if (cap_bytes !== 32'h783612a5) begin n_fail++; $display("FAIL mid_next_bytes got %h want 783612a5", cap_bytes); end
        n_cmp++; if (cap_acks !== 4'h0) begin n_fail++; $display("FAIL mid_next_acks got %b want 0000", cap_acks); end
        drop_start();
    endtask

    task automatic test_start_drop();
        int cyc, hi;
        run_frame(32'h78_38_14_31, 4'h0, 200, cyc);
        n_cmp++; if (cyc != FrameLat) begin n_fail++; $display("FAIL drop_latency got %0d want %0d", cyc, FrameLat); end
        hi = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (tr_end === 1'b1) hi++;
        end
        n_cmp++; if (hi != 1) begin n_fail++; $display("FAIL drop_tr_end_width got %0d want 1", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got %b want 0", busy); end
        n_cmp++; if (cap_bytes !== 32'h78381431) begin n_fail++; $display("FAIL drop_bytes got %h want 78381431", cap_bytes); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        int          cyc, n0, s0, p0, o0, lat_bad;
        words[0] = 32'h78_30_08_82;
        words[1] = 32'h78_47_40_00;
        words[2] = 32'h78_50_1D_40;
        n0 = rec_q.size(); s0 = start_cnt; p0 = stop_cnt; o0 = order_err; lat_bad = 0;
        for (int i = 0; i < 3; i++) begin
            run_frame(words[i], 4'h0, 0, cyc);
            if (cyc != FrameLat) lat_bad++;
            drop_start();
        end
        n_cmp++; if (lat_bad != 0) begin n_fail++; $display("FAIL b2b_latency bad_frames got %0d want 0", lat_bad); end
        n_cmp++; if (rec_q.size() - n0 != 3) begin n_fail++; $display("FAIL b2b_writes got %0d want 3", rec_q.size() - n0); end
        n_cmp++; if (start_cnt - s0 != 3) begin n_fail++; $display("FAIL b2b_starts got %0d want 3", start_cnt - s0); end
        n_cmp++; if (stop_cnt - p0 != 3) begin n_fail++; $display("FAIL b2b_stops got %0d want 3", stop_cnt - p0); end
        n_cmp++; if (order_err - o0 != 0) begin n_fail++; $display("FAIL b2b_order got %0d want 0", order_err - o0); end
        if (rec_q.size() - n0 == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rec_q[n0 + i] !== words[i]) begin
                    n_fail++;
                    $display("FAIL b2b_word%0d got %h want %h", i, rec_q[n0 + i], words[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_nack();
        test_hold_start();
        test_reset_mid_frame();
        test_start_drop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sccb_write_master.md
Name: sccb_write_master

Overview:
- Downstream bus engine for the camera register sequencer. Converts one 32-bit write request {device addr, reg addr[15:8], reg addr[7:0], data} into an SCCB/I2C 4-byte write frame on i2c_sclk/i2c_sdat.
- Reports completion via tr_end and any missing acknowledge via ack.
- Runs directly on the 25 MHz system clock with an internal quarter-bit tick. No separate 20 kHz clock domain.

Parameters:
- CLK_DIV, 62, clk_25M cycles per quarter SCL period (62 gives ~100.8 kHz SCL); minimum 2.
- NUM_BYTES, 4, bytes per frame, sent MSB first from i2c_data[31:0].

Ports:
- clk_25M  in  1  system clock
- camera_rst  in  1  synchronous, active-high reset
- start  in  1  level request; rising (idle and start=1) launches a frame
- i2c_data  in  32  frame contents, captured when a frame launches
- tr_end  out  1  frame complete; held while start stays high
- ack  out  1  1 = at least one ACK slot of the last frame read high (NACK)
- busy  out  1  frame in progress
- i2c_sclk  out  1  SCL, push-pull
- i2c_sdat  inout  1  SDA, open-drain: drives 0 or releases to Z (external pull-up)

Behaviour:
- Reset (camera_rst=1 at a clk_25M edge):
  - state IDLE; tr_end=0, ack=0, busy=0
  - i2c_sclk=1, SDA released
  - tick counter cleared
  - Applies mid-frame too: bus returns to idle on the next cycle; no STOP is generated.
- Tick generator: tick pulses one cycle every CLK_DIV cycles while busy. It is held at zero in IDLE, so the first quarter starts aligned to launch.
- State machine:
  - IDLE: if start=1 and tr_end=0, capture i2c_data into a shift register, clear ack, set busy, go to START.
  - START, 4 quarters: (SCL,SDA) = (1,Z),(1,Z),(1,0),(0,0).
  - BITS, 36 bit slots (4 bytes × 8 data + 1 ACK), 4 quarters each:
    - q0: SCL=0, SDA updated (data bit: 0 → drive low, 1 → release; ACK slot → release).
    - q1, q2: SCL=1. SDA is sampled at the end of q2 in ACK slots; a sample of 1 sets ack (sticky OR across the frame).
    - q3: SCL=0.
    - The shift register shifts after each data bit. The bit counter wraps 8→0 and increments the byte counter.
  - STOP, 4 quarters: (0,0),(1,0),(1,Z),(1,Z).
  - DONE: busy=0, tr_end=1. Stay while start=1. When start=0, clear tr_end and go to IDLE on the same edge.
- Latency: tr_end rises exactly 152×CLK_DIV+1 cycles after the cycle start is sampled high in IDLE.
- A NACK does not abort the frame. All bytes and the STOP are always sent.
- start dropping mid-frame is ignored. The frame completes, and tr_end is then high for exactly one cycle.
- i2c_data changes after launch have no effect on the frame in progress.
- start held high after tr_end does not retrigger. A new frame needs start=0 for at least one cycle first, which matches the sequencer's start/tr_end handshake.
- SDA is never driven high. SDA only changes while SCL=0, except in the START and STOP quarters.

Decomposition:
- Shared package camera_cfg_pkg:
  - state enum (IDLE, START, BITS, STOP, DONE)
  - OV5640_I2C_ADDR = 8'h78
  - bits-per-byte constant (9, including the ACK slot)
  - default CLK_DIV
- One natural sub-module: sccb_quarter_tick (CLK_DIV counter with enable and synchronous clear, 1-cycle tick out).

Test Plan:
- CLK_DIV=4, i2c_data=32'h78310311, slave model ACKs all bytes:
  - SDA bits captured on SCL rising edges read 78,31,03,11 with ACK slots low.
  - START and STOP conditions are observed.
  - tr_end rises at cycle 609; ack=0.
- Slave NACKs byte 3 (reg addr low):
  - ack=1 at tr_end.
  - All 36 slots and the STOP are still generated.
  - The next frame with full ACKs clears ack to 0.
- start held high 100 cycles past tr_end:
  - tr_end stays 1, no SCL activity.
  - start=0 → tr_end=0 the next cycle.
  - start=1 again → new frame begins.
- camera_rst asserted at quarter 2 of bit 5 of byte 2:
  - Next cycle: SCL=1, SDA=Z, busy=0, tr_end=0, ack=0.
  - A subsequent start produces a clean full frame.
- start deasserted during byte 1:
  - Frame completes; tr_end high exactly one cycle; returns to IDLE.
- Three back-to-back frames driven by a sequencer-style FSM (start up, wait tr_end, start down, new data):
  - Each frame's bytes match its data and are separated by STOP then START.
  - The slave model records all three writes.
